// File: rtl/refill_arb.sv
// refill_arb: shares one Wishbone cache-line fetch unit between two cache
// controllers (r0, r1). One line-miss request is granted at a time. Its
// address goes to the fetch unit, and the ack, the refill word strobes and
// the done pulse are relayed back to the owning controller only.
//
// Ports
//   clock, reset        cache clock, synchronous active-high reset
//   rN_fetch_i/addr_i   line-miss request (level) and miss address
//   rN_ack_o            1-cycle pulse: fetch unit accepted rN's miss
//   rN_write_o          refill word strobe for rN
//   rN_done_o           1-cycle pulse: rN's line is complete
//   r_waddr_o/r_data_o  shared refill word address/data (pass-through)
//   f_miss_o/f_addr_o   miss request and latched address to the fetch unit
//   f_ack_i/f_done_i    fetch unit accepted / finished the line
//   f_busy_i            fetch unit busy; blocks new grants
//   f_write_i/waddr/data refill word from the fetch unit
//   grant_o             one-hot owner, 00 when idle
//   busy_o              arbiter not idle
//
// Build option: define REFILL_ARB_RR_EN for round-robin arbitration;
// otherwise r0 has fixed priority over r1.
module refill_arb #(
  parameter int ADDRESS = 18,
  parameter int WIDTH   = 32,
  parameter int WADDR   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               r0_fetch_i,
  input  logic [ADDRESS-1:0] r0_addr_i,
  output logic               r0_ack_o,
  output logic               r0_write_o,
  output logic               r0_done_o,
  input  logic               r1_fetch_i,
  input  logic [ADDRESS-1:0] r1_addr_i,
  output logic               r1_ack_o,
  output logic               r1_write_o,
  output logic               r1_done_o,
  output logic [WADDR-1:0]   r_waddr_o,
  output logic [WIDTH-1:0]   r_data_o,
  output logic               f_miss_o,
  output logic [ADDRESS-1:0] f_addr_o,
  input  logic               f_ack_i,
  input  logic               f_done_i,
  input  logic               f_busy_i,
  input  logic               f_write_i,
  input  logic [WADDR-1:0]   f_waddr_i,
  input  logic [WIDTH-1:0]   f_data_i,
  output logic [1:0]         grant_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, FILL, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [ADDRESS-1:0] addr_q, addr_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         win;

`ifdef REFILL_ARB_RR_EN
  // prio_q = 1 favours r1; it points away from whoever was served last.
  logic prio_q, prio_d;

  always_comb begin
    win = 2'b00;
    if (r0_fetch_i && r1_fetch_i) win = prio_q ? 2'b10 : 2'b01;
    else if (r0_fetch_i)          win = 2'b01;
    else if (r1_fetch_i)          win = 2'b10;
  end

  always_comb begin
    prio_d = prio_q;
    if (state_q == RELEASE) prio_d = grant_q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`else
  always_comb begin
    win = 2'b00;
    if (r0_fetch_i)      win = 2'b01;
    else if (r1_fetch_i) win = 2'b10;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ack_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (!f_busy_i && (win != 2'b00)) begin
          grant_d = win;
          addr_d  = win[0] ? r0_addr_i : r1_addr_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (f_ack_i) begin
          ack_d   = grant_q;
          // A fetch unit that acks and finishes together skips FILL so
          // ack and done land in the same cycle.
          state_d = f_done_i ? RELEASE : FILL;
        end
      end
      FILL: begin
        if (f_done_i) state_d = RELEASE;
      end
      RELEASE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      addr_q  <= '0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
    end
  end

  logic filling;
  assign filling = (state_q == ISSUE) || (state_q == FILL);

  assign r0_ack_o   = ack_q[0];
  assign r1_ack_o   = ack_q[1];
  assign r0_done_o  = (state_q == RELEASE) && grant_q[0];
  assign r1_done_o  = (state_q == RELEASE) && grant_q[1];
  // Words outside ISSUE/FILL have no owner and are dropped.
  assign r0_write_o = f_write_i && grant_q[0] && filling;
  assign r1_write_o = f_write_i && grant_q[1] && filling;
  assign r_waddr_o  = f_waddr_i;
  assign r_data_o   = f_data_i;
  assign f_miss_o   = (state_q == ISSUE);
  assign f_addr_o   = addr_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_refill_arb.sv
module tb_refill_arb;
  localparam int ADDRESS = 18;
  localparam int WIDTH   = 32;
  localparam int WADDR   = 8;
`ifdef REFILL_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               r0_fetch_i, r1_fetch_i;
  logic [ADDRESS-1:0] r0_addr_i, r1_addr_i;
  logic               r0_ack_o, r0_write_o, r0_done_o;
  logic               r1_ack_o, r1_write_o, r1_done_o;
  logic [WADDR-1:0]   r_waddr_o;
  logic [WIDTH-1:0]   r_data_o;
  logic               f_miss_o;
  logic [ADDRESS-1:0] f_addr_o;
  logic               f_ack_i, f_done_i, f_busy_i, f_write_i;
  logic [WADDR-1:0]   f_waddr_i;
  logic [WIDTH-1:0]   f_data_i;
  logic [1:0]         grant_o;
  logic               busy_o;

  refill_arb #(.ADDRESS(ADDRESS), .WIDTH(WIDTH), .WADDR(WADDR)) dut (
    .clock(clock), .reset(reset),
    .r0_fetch_i(r0_fetch_i), .r0_addr_i(r0_addr_i), .r0_ack_o(r0_ack_o),
    .r0_write_o(r0_write_o), .r0_done_o(r0_done_o),
    .r1_fetch_i(r1_fetch_i), .r1_addr_i(r1_addr_i), .r1_ack_o(r1_ack_o),
    .r1_write_o(r1_write_o), .r1_done_o(r1_done_o),
    .r_waddr_o(r_waddr_o), .r_data_o(r_data_o),
    .f_miss_o(f_miss_o), .f_addr_o(f_addr_o), .f_ack_i(f_ack_i),
    .f_done_i(f_done_i), .f_busy_i(f_busy_i), .f_write_i(f_write_i),
    .f_waddr_i(f_waddr_i), .f_data_i(f_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit rr_fav = 1'b0;  // model: 1 means r1 wins a tie (round-robin only)

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference arbitration rule from the request levels alone.
  function automatic logic [1:0] pick(input bit p0, input bit p1);
    if (p0 && p1 && RR_EN && rr_fav) return 2'b10;
    if (p0) return 2'b01;
    if (p1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [9:0] ctl;
    return {grant_o, busy_o, f_miss_o, r0_ack_o, r1_ack_o,
            r0_done_o, r1_done_o, r0_write_o, r1_write_o};
  endfunction

  // One complete miss, starting from an idle cycle with requests driven.
  task automatic fill(input logic [1:0] g, input int hold, input int ackd,
                      input int nw, input bit same, input bit wdraw, input bit dense);
    logic [ADDRESS-1:0] ea;
    int n0, n1, ne;
    ea = g[0] ? r0_addr_i : r1_addr_i;
    n0 = 0; n1 = 0; ne = 0;
    f_busy_i = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_grant", 64'(grant_o), 64'(0));
      chk("hold_miss", 64'(f_miss_o), 64'(0));
      if (i == hold - 1) f_busy_i = 1'b0;
    end
    tick;
    chk("grant", 64'(grant_o), 64'(g));
    chk("f_addr", 64'(f_addr_o), 64'(ea));
    chk("miss_on", 64'({f_miss_o, busy_o}), 64'(2'b11));
    if (wdraw) begin
      if (g[0]) r0_fetch_i = 1'b0; else r1_fetch_i = 1'b0;
    end
    for (int i = 0; i < ackd; i++) begin
      tick;
      chk("miss_wait", 64'(f_miss_o), 64'(1));
      chk("ack_early", 64'({r1_ack_o, r0_ack_o}), 64'(0));
    end
    f_ack_i = 1'b1; f_done_i = same;
    tick;
    f_ack_i = 1'b0; f_done_i = 1'b0;
    chk("ack", 64'({r1_ack_o, r0_ack_o}), 64'(g));
    chk("miss_off", 64'(f_miss_o), 64'(0));
    if (g[0]) r0_fetch_i = 1'b0; else r1_fetch_i = 1'b0;
    if (same) begin
      chk("done_same", 64'({r1_done_o, r0_done_o}), 64'(g));
    end else begin
      chk("done_early", 64'({r1_done_o, r0_done_o}), 64'(0));
      for (int i = 0; i < nw; i++) begin
        f_write_i = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
        f_waddr_i = WADDR'($urandom);
        f_data_i  = $urandom;
        #1;
        chk("wr_route", 64'({r1_write_o, r0_write_o}), 64'(f_write_i ? g : 2'b00));
        chk("wr_data", 64'({r_waddr_o, r_data_o}), 64'({f_waddr_i, f_data_i}));
        n0 += int'(r0_write_o); n1 += int'(r1_write_o); ne += int'(f_write_i);
        tick;
      end
      f_write_i = 1'b0; f_done_i = 1'b1;
      tick;
      f_done_i = 1'b0;
      chk("done", 64'({r1_done_o, r0_done_o}), 64'(g));
      chk("ack_clr", 64'({r1_ack_o, r0_ack_o}), 64'(0));
      chk("wr_cnt0", 64'(n0), 64'(g[0] ? ne : 0));
      chk("wr_cnt1", 64'(n1), 64'(g[1] ? ne : 0));
    end
    // Release cycle: a stray word has no owner.
    f_write_i = 1'b1;
    #1;
    chk("wr_drop_rel", 64'({r1_write_o, r0_write_o}), 64'(0));
    chk("busy_rel", 64'(busy_o), 64'(1));
    tick;
    chk("idle", 64'(ctl()), 64'(0));
    f_write_i = 1'b0;
    rr_fav = g[0];
  endtask

  initial begin
    logic [1:0] dual_exp [4];
    reset = 1'b1;
    r0_fetch_i = 1'b0; r1_fetch_i = 1'b0; r0_addr_i = '0; r1_addr_i = '0;
    f_ack_i = 1'b0; f_done_i = 1'b0; f_busy_i = 1'b0; f_write_i = 1'b0;
    f_waddr_i = '0; f_data_i = '0;
    repeat (3) tick;
    chk("rst_ctl", 64'(ctl()), 64'(0));
    chk("rst_addr", 64'(f_addr_o), 64'(0));
    reset = 1'b0;
    rr_fav = 1'b0;
    tick;

    // Dual continuous requests.
    dual_exp = RR_EN ? '{2'b01, 2'b10, 2'b01, 2'b10} : '{2'b01, 2'b01, 2'b01, 2'b01};
    r0_addr_i = ADDRESS'($urandom); r1_addr_i = ADDRESS'($urandom);
    for (int k = 0; k < 4; k++) begin
      if (!r0_fetch_i) begin r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom); end
      if (!r1_fetch_i) begin r1_fetch_i = 1'b1; r1_addr_i = ADDRESS'($urandom); end
      fill(dual_exp[k], 0, $urandom_range(0, 2), $urandom_range(0, 4), 1'b0, 1'b0, 1'b0);
    end
    r1_fetch_i = 1'b0;
    if (r0_fetch_i) begin
      fill(2'b01, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    end

    // Single r0 miss: ack after 3 cycles, 16 words.
    r0_fetch_i = 1'b1; r0_addr_i = 18'h00005;
    fill(2'b01, 0, 3, 16, 1'b0, 1'b0, 1'b1);

    // Busy hold-off with r1 only.
    r1_fetch_i = 1'b1; r1_addr_i = ADDRESS'($urandom);
    fill(2'b10, 4, 1, 3, 1'b0, 1'b0, 1'b0);

    // Ack and done in the same cycle.
    r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom);
    fill(2'b01, 0, 1, 0, 1'b1, 1'b0, 1'b0);

    // Withdrawn request.
    r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom);
    fill(2'b01, 0, 2, 5, 1'b0, 1'b1, 1'b0);

    // Reset mid-fill after 5 of 16 words.
    r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom);
    tick;
    chk("mr_grant", 64'(grant_o), 64'(2'b01));
    f_ack_i = 1'b1;
    tick;
    f_ack_i = 1'b0; r0_fetch_i = 1'b0;
    chk("mr_ack", 64'({r1_ack_o, r0_ack_o}), 64'(2'b01));
    for (int i = 0; i < 5; i++) begin
      f_write_i = 1'b1; f_waddr_i = WADDR'(i);
      #1;
      chk("mr_wr", 64'({r1_write_o, r0_write_o}), 64'(2'b01));
      tick;
    end
    reset = 1'b1;
    tick;
    chk("mr_ctl", 64'(ctl()), 64'(0));
    chk("mr_addr", 64'(f_addr_o), 64'(0));
    reset = 1'b0; f_write_i = 1'b0; f_done_i = 1'b1;
    rr_fav = 1'b0;
    tick;
    f_done_i = 1'b0;
    chk("mr_nodone", 64'(ctl()), 64'(0));
    r1_fetch_i = 1'b1; r1_addr_i = ADDRESS'($urandom);
    fill(2'b10, 0, 1, 4, 1'b0, 1'b0, 1'b0);

    // Random traffic against the arbitration model.
    for (int it = 0; it < 40; it++) begin
      if (!r0_fetch_i && $urandom_range(0, 1) == 1) begin
        r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom);
      end
      if (!r1_fetch_i && $urandom_range(0, 1) == 1) begin
        r1_fetch_i = 1'b1; r1_addr_i = ADDRESS'($urandom);
      end
      if (!r0_fetch_i && !r1_fetch_i) begin
        if ($urandom_range(0, 1) == 1) begin r0_fetch_i = 1'b1; r0_addr_i = ADDRESS'($urandom); end
        else begin r1_fetch_i = 1'b1; r1_addr_i = ADDRESS'($urandom); end
      end
      fill(pick(r0_fetch_i, r1_fetch_i), $urandom_range(0, 2), $urandom_range(0, 3),
           $urandom_range(0, 6), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
